// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: control word layout, bubble value,
// counter width and the valid gate applied to decode controls.
package id_ex_stage_pkg;

   localparam int CTRL_W = 10;

   localparam int CTRL_REG_WRITE  = 0;
   localparam int CTRL_MEM_TO_REG = 1;
   localparam int CTRL_MEM_READ   = 2;
   localparam int CTRL_MEM_WRITE  = 3;
   localparam int CTRL_ALU_SRC    = 4;
   localparam int CTRL_REG_DST    = 5;
   localparam int CTRL_BRANCH     = 6;
   localparam int CTRL_ALU_OP_LO  = 7;
   localparam int CTRL_ALU_OP_HI  = 9;

   localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

   localparam int PERF_W = 32;

   // An invalid slot must never carry side-effecting controls.
   function automatic logic [CTRL_W-1:0] ctrl_gate(
      input logic              valid,
      input logic [CTRL_W-1:0] ctrl
   );
      return valid ? ctrl : CTRL_BUBBLE;
   endfunction

endpackage

// File: rtl/id_ex_stage_sat_free_counter.sv
// sat_free_counter: W-bit up counter with enable and sync clear,
// wraps freely. Ports: clk, reset, clear, en -> count.
module sat_free_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (en)
         count <= count + W'(1);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: flush > stall > load, imm sign-extend.
// Perf counters present only with ID_EX_PERF_CNT_EN, else tied 0.
import id_ex_stage_pkg::*;

module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc_plus4,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [15:0]       id_imm16,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc_plus4,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm32,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [PERF_W-1:0] bubble_cnt,
   output logic [PERF_W-1:0] stall_cnt
);

   logic [DATA_W-1:0] imm_sx;

   assign imm_sx = {{(DATA_W-16){id_imm16[15]}}, id_imm16};

   always_ff @(posedge clk or posedge reset) begin
      if (reset || flush) begin
         ex_valid    <= 1'b0;
         ex_pc_plus4 <= '0;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_imm32    <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= CTRL_BUBBLE;
      end else if (!stall) begin
         ex_valid    <= id_valid;
         ex_pc_plus4 <= id_pc_plus4;
         ex_rd1      <= id_rd1;
         ex_rd2      <= id_rd2;
         ex_imm32    <= imm_sx;
         ex_rs       <= id_rs;
         ex_rt       <= id_rt;
         ex_rd       <= id_rd;
         ex_ctrl     <= ctrl_gate(id_valid, id_ctrl);
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic bubble_en;
   logic stall_en;

   // A load of an invalid slot is a bubble just like a flush.
   assign bubble_en = flush | (~stall & ~id_valid);
   assign stall_en  = stall & ~flush;

   sat_free_counter #(.W(PERF_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .en    (bubble_en),
      .count (bubble_cnt)
   );

   sat_free_counter #(.W(PERF_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .en    (stall_en),
      .count (stall_cnt)
   );
`else
   assign bubble_cnt = '0;
   assign stall_cnt  = '0;
`endif

endmodule
